// File: rtl/lcd_pkg.sv
// Shared LCD scheduler definitions: FSM state encoding, HD44780 command bytes, init ROM.
// No timing of its own; pure constants and helpers.
// Optional feature macro LCD_INIT_SEQ_EN adds the power-on and init states.
package lcd_pkg;

`ifdef LCD_INIT_SEQ_EN
    typedef enum logic [2:0] {
        ST_PWR, ST_INIT, ST_IDLE, ST_SETUP, ST_EN_HI, ST_HOLD, ST_WAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_EN_HI, ST_HOLD, ST_WAIT
    } state_t;
`endif

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] HOME     = 8'h02;

    localparam int INIT_LEN = 4;

    // Controller bring-up bytes, all sent as commands (rs=0).
    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = FUNC_SET;
            2'd1:    b = DISP_ON;
            2'd2:    b = ENTRY;
            default: b = CLEAR;
        endcase
        return b;
    endfunction

    // Clear/home (and 8'h03, which the controller also treats as home) need the long settle.
    function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
        return !rs && (data == CLEAR || data == HOME || data == 8'h03);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_bus_scheduler_if.sv
// Renderer-to-scheduler request handshake plus the LCD pin bundle.
// Combinational bundle, no latency.
// A request transfers when req_valid[i] & req_ready[i]; the requester holds it until then.
interface lcd_bus_scheduler_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_rs;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        busy;
    logic        rs;
    logic        rw;
    logic        enable;
    logic [7:0]  data;

    modport master (
        output req_valid, req_rs, req_data,
        input  req_ready, busy, rs, rw, enable, data
    );

    modport slave (
        input  req_valid, req_rs, req_data,
        output req_ready, busy, rs, rw, enable, data
    );
endinterface

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin grant between the face and stats renderers.
// Combinational grant; pointer updates on the cycle a grant is taken.
// Grant is only ever given to a valid port; the caller gates it with its own readiness.
module lcd_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       take,
    output logic [1:0] grant
);
    logic prio1;   // 1 = port 1 wins a tie

    // Tie goes to the port not served last; a lone requester always wins.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = prio1 ? 2'b10 : 2'b01;
        end
    end

    // Serving port 0 hands priority to port 1 and vice versa.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio1 <= 1'b0;
        end else if (take) begin
            prio1 <= grant[0];
        end
    end
endmodule

// File: rtl/lcd_bus_scheduler.sv
// Shares the 1602 LCD bus between two renderers one byte at a time with HD44780 strobe timing.
// Byte on pins from transfer+1; next transfer after SETUP+EN_HIGH+HOLD+WAIT(_LONG) cycles.
// req_ready is offered only in IDLE; requests arriving mid-write are held off. Macro: LCD_INIT_SEQ_EN.
module lcd_bus_scheduler #(
    parameter int T_SETUP     = 2,
    parameter int T_EN_HIGH   = 25,
    parameter int T_HOLD      = 2,
    parameter int T_WAIT      = 2500,
    parameter int T_WAIT_LONG = 82000,
    parameter int T_PWR       = 750000
) (
    input  logic                clk,
    input  logic                rst,
    lcd_bus_scheduler_if.slave  bus
);
    import lcd_pkg::*;

    localparam int T_MAX = max_int(max_int(max_int(T_SETUP, T_EN_HIGH), max_int(T_HOLD, T_WAIT)),
                                   max_int(T_WAIT_LONG, T_PWR));
    localparam int CNT_W = $clog2(T_MAX + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    state_t      state, state_nxt;
    cnt_t        cnt, cnt_nxt;
    logic [1:0]  grant;
    logic        xfer;
    logic        sel;
    logic        rs_q;
    logic [7:0]  data_q;

    lcd_rr_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (bus.req_valid),
        .take  (xfer),
        .grant (grant)
    );

    // rst gates ready/busy directly so both read correctly while reset is held.
    assign bus.req_ready = (state == ST_IDLE && !rst) ? grant : 2'b00;
    assign xfer          = |bus.req_ready;
    assign sel           = grant[1];
    assign bus.busy      = rst || (state != ST_IDLE);
    assign bus.rs        = rs_q;
    assign bus.data      = data_q;
    assign bus.rw        = 1'b0;
    assign bus.enable    = (state == ST_EN_HI);

`ifdef LCD_INIT_SEQ_EN
    logic [2:0] init_idx;
    logic       init_pending;
    assign init_pending = (init_idx != 3'(INIT_LEN));
`endif

    // Next state and counter: the counter loads on every state entry, the state leaves at zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != '0) ? cnt - cnt_t'(1) : cnt;
        case (state)
`ifdef LCD_INIT_SEQ_EN
            ST_PWR: begin
                if (cnt == '0) begin
                    state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                state_nxt = ST_SETUP;
                cnt_nxt   = cnt_t'(T_SETUP - 1);
            end
`endif
            ST_IDLE: begin
                if (xfer) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = cnt_t'(T_SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = ST_EN_HI;
                    cnt_nxt   = cnt_t'(T_EN_HIGH - 1);
                end
            end
            ST_EN_HI: begin
                if (cnt == '0) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = cnt_t'(T_HOLD - 1);
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = needs_long_wait(rs_q, data_q) ? cnt_t'(T_WAIT_LONG - 1)
                                                              : cnt_t'(T_WAIT - 1);
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
                    state_nxt = init_pending ? ST_INIT : ST_IDLE;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; with the init sequence the counter is preloaded for the power-on wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef LCD_INIT_SEQ_EN
            state <= ST_PWR;
            cnt   <= cnt_t'(T_PWR - 1);
`else
            state <= ST_IDLE;
            cnt   <= '0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Latch the granted byte (or the next init byte); it stays on the pins until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_q   <= 1'b0;
            data_q <= 8'h00;
        end else if (xfer) begin
            rs_q   <= bus.req_rs[sel];
            data_q <= sel ? bus.req_data[15:8] : bus.req_data[7:0];
        end
`ifdef LCD_INIT_SEQ_EN
        else if (state == ST_INIT) begin
            rs_q   <= 1'b0;
            data_q <= init_rom(init_idx[1:0]);
        end
`endif
    end

`ifdef LCD_INIT_SEQ_EN
    // Init ROM index advances once per issued init byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_idx <= 3'd0;
        end else if (state == ST_INIT) begin
            init_idx <= init_idx + 3'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Self-checking bench for lcd_bus_scheduler with shortened timing parameters.
// Inputs driven on the falling edge, outputs sampled 1 ns later.
// Writes are scoreboarded: expected bytes queued at transfer, popped on each enable pulse.
module tb_lcd_bus_scheduler;
    localparam int T_SETUP     = 1;
    localparam int T_EN_HIGH   = 3;
    localparam int T_HOLD      = 1;
    localparam int T_WAIT      = 5;
    localparam int T_WAIT_LONG = 20;
    localparam int T_PWR       = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_bus_scheduler_if bus ();

    lcd_bus_scheduler #(
        .T_SETUP     (T_SETUP),
        .T_EN_HIGH   (T_EN_HIGH),
        .T_HOLD      (T_HOLD),
        .T_WAIT      (T_WAIT),
        .T_WAIT_LONG (T_WAIT_LONG),
        .T_PWR       (T_PWR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    int         grant_log[$];
    int         pulses     = 0;
    int         xfer_total = 0;

    logic [1:0] obs_ready;
    logic       obs_busy, obs_en, obs_rs, obs_xfer;
    logic [7:0] obs_data;
    int         obs_port = -1;

    typedef struct {
        int         port;
        logic       rs;
        logic [7:0] data;
        int         gap;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: sample 1 ns after the falling edge, record any transfer, move to the next falling edge.
    task automatic tick();
        #1;
        obs_ready = bus.req_ready;
        obs_busy  = bus.busy;
        obs_en    = bus.enable;
        obs_rs    = bus.rs;
        obs_data  = bus.data;
        obs_xfer  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                obs_xfer = 1'b1;
                obs_port = i;
                exp_q.push_back({bus.req_rs[i], bus.req_data[i*8 +: 8]});
                grant_log.push_back(i);
                xfer_total++;
            end
        end
        @(negedge clk);
    endtask

    // Enable monitor: each rising enable consumes one expected byte; width is checked on the fall.
    logic       prev_en = 1'b0;
    int         en_len  = 0;
    logic [8:0] cur     = '0;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_en = 1'b0;
            en_len  = 0;
        end else begin
            if (bus.enable) begin
                if (!prev_en) begin
                    pulses++;
                    en_len = 1;
                    chk("rw_low", bus.rw, 1'b0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 1'b1, 1'b0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("lcd_byte", {bus.rs, bus.data}, cur);
                    end
                end else begin
                    en_len++;
                    chk("byte_stable_en", {bus.rs, bus.data}, cur);
                end
            end else if (prev_en) begin
                chk("enable_width", en_len, T_EN_HIGH);
            end
            prev_en = bus.enable;
        end
    end

    task automatic reset_seq();
        int   n;
        int   p0;
        logic rdy_seen;
        rst = 1'b1;
        exp_q.delete();
        grant_log.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        p0 = pulses;
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
        rdy_seen = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (obs_busy && obs_ready != 2'b00) rdy_seen = 1'b1;
        end while (obs_busy && n < 1000);
        chk("init_done", obs_busy, 1'b0);
        chk("init_ready_zero", rdy_seen, 1'b0);
        chk("init_writes", pulses - p0, 4);
`else
        n = 0;
        p0 = 0;
        rdy_seen = 1'b0;
        tick();
        chk("busy_after_release", obs_busy, 1'b0);
`endif
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (obs_busy && n < 200);
        chk(name, obs_busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, gap, p0, x0;
        logic ok_data;
        int exp_g[4];
        exp_g = '{0, 1, 0, 1};

        vecs[0] = '{0, 1'b1, 8'h41, 11};
        vecs[1] = '{1, 1'b0, 8'h01, 26};
        vecs[2] = '{1, 1'b0, 8'h80, 11};
        vecs[3] = '{0, 1'b0, 8'h02, 26};
        vecs[4] = '{1, 1'b0, 8'h03, 26};
        vecs[5] = '{0, 1'b1, 8'h01, 11};
        vecs[6] = '{1, 1'b0, 8'h04, 11};

        // Reset values while reset is held, with both ports requesting.
        bus.req_valid = 2'b11;
        bus.req_rs    = 2'b11;
        bus.req_data  = 16'hFFFF;
        @(negedge clk);
        #1;
        chk("reset_rs", bus.rs, 1'b0);
        chk("reset_data", bus.data, 8'h00);
        chk("reset_enable", bus.enable, 1'b0);
        chk("reset_rw", bus.rw, 1'b0);
        chk("reset_busy", bus.busy, 1'b1);
        chk("reset_ready", bus.req_ready, 2'b00);
        bus.req_valid = 2'b00;
        reset_seq();

        // Single-port writes: grant, byte stability SETUP..HOLD, transfer-to-next-ready gap.
        for (int v = 0; v < 7; v++) begin
            bus.req_rs   = 2'b00;
            bus.req_data = 16'h0000;
            bus.req_rs[vecs[v].port] = vecs[v].rs;
            bus.req_data[vecs[v].port*8 +: 8] = vecs[v].data;
            bus.req_valid = 2'b01 << vecs[v].port;
            n = 0;
            do begin
                tick();
                n++;
            end while (!obs_xfer && n < 100);
            chk($sformatf("v%0d_xfer", v), obs_xfer, 1'b1);
            chk($sformatf("v%0d_grant", v), obs_port, vecs[v].port);
            gap = 0;
            ok_data = 1'b1;
            do begin
                tick();
                gap++;
                if (gap <= T_SETUP + T_EN_HIGH + T_HOLD &&
                    (obs_data !== vecs[v].data || obs_rs !== vecs[v].rs)) ok_data = 1'b0;
            end while (!obs_xfer && gap < 100);
            chk($sformatf("v%0d_gap", v), gap, vecs[v].gap);
            chk($sformatf("v%0d_stable", v), ok_data, 1'b1);
            bus.req_valid = 2'b00;
            wait_idle($sformatf("v%0d_idle", v));
        end

        // Reset in the middle of an enable pulse, then both ports requesting continuously.
        bus.req_rs    = 2'b01;
        bus.req_data  = 16'h0055;
        bus.req_valid = 2'b01;
        n = 0;
        do begin
            tick();
            n++;
        end while (!obs_xfer && n < 100);
        bus.req_valid = 2'b00;
        n = 0;
        do begin
            tick();
            n++;
        end while (!obs_en && n < 100);
        chk("abort_saw_enable", obs_en, 1'b1);
        bus.req_data  = 16'hB0A0;
        bus.req_rs    = 2'b11;
        bus.req_valid = 2'b11;
        #1 rst = 1'b1;
        #1;
        chk("abort_enable", bus.enable, 1'b0);
        chk("abort_busy", bus.busy, 1'b1);
        chk("abort_ready", bus.req_ready, 2'b00);
        reset_seq();
        n = 0;
        while (grant_log.size() < 4 && n < 400) begin
            tick();
            n++;
        end
        bus.req_valid = 2'b00;
        chk("rr_grant_count", grant_log.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), (grant_log.size() > i) ? grant_log[i] : -1, exp_g[i]);
        end
        wait_idle("rr_idle");
        chk("sb_drained_rr", exp_q.size(), 0);

        // A request raised and dropped during WAIT must not produce a write.
        bus.req_rs    = 2'b01;
        bus.req_data  = 16'h0033;
        bus.req_valid = 2'b01;
        n = 0;
        do begin
            tick();
            n++;
        end while (!obs_xfer && n < 100);
        bus.req_valid = 2'b00;
        repeat (7) tick();
        p0 = pulses;
        x0 = xfer_total;
        bus.req_valid = 2'b01;
        tick();
        chk("wait_req_ready", obs_ready, 2'b00);
        chk("wait_req_busy", obs_busy, 1'b1);
        bus.req_valid = 2'b00;
        tick();
        tick();
        chk("wait_last_busy", obs_busy, 1'b1);
        tick();
        chk("busy_fall", obs_busy, 1'b0);
        repeat (20) tick();
        chk("no_extra_write", pulses, p0);
        chk("no_extra_xfer", xfer_total, x0);
        chk("sb_drained_end", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
